dll_digital_loop_filter: RTL and testbench

//  Digital loop filter for the DLL, directly downstream of the bang-bang phase detector (dff sampling clk_out on clk_in).

---
 rtl/dll_digital_loop_filter_pkg.sv | 25 ++
 rtl/dll_digital_loop_filter_if.sv | 20 ++
 rtl/dll_digital_loop_filter_lock.sv | 56 +++++
 rtl/dll_digital_loop_filter.sv | 89 ++++++++
 tb/tb_dll_digital_loop_filter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/dll_digital_loop_filter_pkg.sv
// Shared types and the saturating code-step helper for the DLL loop filter.
package dll_pkg;

   typedef enum logic [1:0] {DEC_HOLD = 2'd0, DEC_UP = 2'd1, DEC_DN = 2'd2} dec_t;

   typedef struct packed {
      logic        blocked;
      logic [31:0] code;
   } step_t;

   // Codes are carried at 32 bits so one helper serves any CODE_W below 32.
   function automatic step_t sat_step(input logic [31:0] code, input dec_t dec,
                                      input logic [31:0] max);
      step_t s;
      s.blocked = 1'b0;
      s.code    = code;
      case (dec)
         DEC_UP:  if (code >= max)   s.blocked = 1'b1; else s.code = code + 32'd1;
         DEC_DN:  if (code == 32'd0) s.blocked = 1'b1; else s.code = code - 32'd1;
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dll_digital_loop_filter_if.sv
// Control/status bundle between the loop filter and its PD / delay-line environment.
interface dll_digital_loop_filter_if #(parameter int CODE_W = 8);
   import dll_pkg::*;

   logic              en;
   logic              pd_q;
   logic              load;
   logic [CODE_W-1:0] load_val;
   logic [CODE_W-1:0] delay_code;
   dec_t              dec;
   logic              code_update;
   logic              sat_hi;
   logic              sat_lo;
   logic              lock;

   modport master (output en, pd_q, load, load_val,
                   input  delay_code, dec, code_update, sat_hi, sat_lo, lock);
   modport slave  (input  en, pd_q, load, load_val,
                   output delay_code, dec, code_update, sat_hi, sat_lo, lock);
endinterface

// File: rtl/dll_digital_loop_filter_lock.sv
// Lock detector: counts consecutive reversal/hold vs same-direction decisions.
module dll_lock_detect
   import dll_pkg::*;
#(
   parameter int LOCK_CNT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic dec_valid,
   input  dec_t dec,
   output logic lock
);

   localparam int            CW      = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

   logic [CW-1:0] rev_cnt, same_cnt, rev_nxt, same_nxt;
   logic          have_dir, is_same;
   dec_t          last_dir;

   // HOLD is treated like a reversal: the loop is sitting on the edge.
   always_comb begin
      is_same  = (dec != DEC_HOLD) && (!have_dir || dec == last_dir);
      rev_nxt  = '0;
      same_nxt = '0;
      if (is_same) same_nxt = (same_cnt == CNT_MAX) ? same_cnt : same_cnt + 1'b1;
      else         rev_nxt  = (rev_cnt  == CNT_MAX) ? rev_cnt  : rev_cnt  + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rev_cnt  <= '0;
         same_cnt <= '0;
         have_dir <= 1'b0;
         last_dir <= DEC_HOLD;
         lock     <= 1'b0;
      end else if (clr) begin
         rev_cnt  <= '0;
         same_cnt <= '0;
         have_dir <= 1'b0;
         last_dir <= DEC_HOLD;
         lock     <= 1'b0;
      end else if (dec_valid) begin
         rev_cnt  <= rev_nxt;
         same_cnt <= same_nxt;
         if (dec != DEC_HOLD) begin
            last_dir <= dec;
            have_dir <= 1'b1;
         end
         if (rev_nxt == CNT_MAX)       lock <= 1'b1;
         else if (same_nxt == CNT_MAX) lock <= 1'b0;
      end
   end

endmodule

// File: rtl/dll_digital_loop_filter.sv
// DLL loop filter: majority vote over WIN_LEN PD samples steps a saturating delay code.
module dll_digital_loop_filter
   import dll_pkg::*;
#(
   parameter int CODE_W    = 8,
   parameter int INIT_CODE = 128,
   parameter int WIN_LEN   = 8,
   parameter int LOCK_CNT  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   dll_digital_loop_filter_if.slave bus
);

   localparam int                  WW       = $clog2(WIN_LEN);
   localparam int                  VW       = WW + 2;
   localparam logic [CODE_W-1:0]   CODE_MAX = '1;
   localparam logic [WW-1:0]       WIN_LAST = WW'(WIN_LEN - 1);
   localparam logic signed [VW-1:0] ONE     = 1;

   logic [WW-1:0]        win_cnt;
   logic signed [VW-1:0] vote, vote_nxt;
   logic [CODE_W-1:0]    code_q;
   dec_t                 dec_q, dec_nxt;
   logic                 upd_q, sat_hi_q, sat_lo_q, decide, lock_w;
   step_t                step;

   always_comb begin
      vote_nxt = bus.pd_q ? vote + ONE : vote - ONE;
      dec_nxt  = DEC_HOLD;
      if (vote_nxt[VW-1])      dec_nxt = DEC_DN;
      else if (vote_nxt != '0) dec_nxt = DEC_UP;
      step   = sat_step(32'(code_q), dec_nxt, 32'(CODE_MAX));
      decide = bus.en && !bus.load && (win_cnt == WIN_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q   <= CODE_W'(INIT_CODE);
         dec_q    <= DEC_HOLD;
         upd_q    <= 1'b0;
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
         win_cnt  <= '0;
         vote     <= '0;
      end else if (bus.load) begin
         code_q   <= bus.load_val;
         upd_q    <= 1'b0;
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
         win_cnt  <= '0;
         vote     <= '0;
      end else if (!bus.en) begin
         // partial window is thrown away; code, dec and flags hold
         upd_q   <= 1'b0;
         win_cnt <= '0;
         vote    <= '0;
      end else if (decide) begin
         code_q   <= step.code[CODE_W-1:0];
         dec_q    <= dec_nxt;
         upd_q    <= 1'b1;
         sat_hi_q <= step.blocked && (dec_nxt == DEC_UP);
         sat_lo_q <= step.blocked && (dec_nxt == DEC_DN);
         win_cnt  <= '0;
         vote     <= '0;
      end else begin
         upd_q   <= 1'b0;
         win_cnt <= win_cnt + 1'b1;
         vote    <= vote_nxt;
      end
   end

   dll_lock_detect #(.LOCK_CNT(LOCK_CNT)) u_lock (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (bus.load),
      .dec_valid (decide),
      .dec       (dec_nxt),
      .lock      (lock_w)
   );

   assign bus.delay_code  = code_q;
   assign bus.dec         = dec_q;
   assign bus.code_update = upd_q;
   assign bus.sat_hi      = sat_hi_q;
   assign bus.sat_lo      = sat_lo_q;
   assign bus.lock        = lock_w;

endmodule

// File: tb/tb_dll_digital_loop_filter.sv
// Scoreboard bench for dll_digital_loop_filter: directed windows, monitor checks each code_update.
module tb_dll_digital_loop_filter;
   import dll_pkg::*;

   typedef struct packed {
      logic [7:0] code;
      dec_t       dec;
      logic       sat_hi;
      logic       sat_lo;
      logic       lock;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dll_digital_loop_filter_if #(.CODE_W(8)) bus ();

   dll_digital_loop_filter #(.CODE_W(8), .INIT_CODE(128), .WIN_LEN(8), .LOCK_CNT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every update must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.code_update === 1'b1) begin
         exp_t e, g;
         g = '{code: bus.delay_code, dec: bus.dec, sat_hi: bus.sat_hi,
               sat_lo: bus.sat_lo, lock: bus.lock};
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_update: got code=%0d dec=%0d expected no update (t=%0t)",
                     g.code, g.dec, $time);
         end else begin
            e = sb_q.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL update: got code=%0d dec=%0d hi=%0b lo=%0b lock=%0b expected code=%0d dec=%0d hi=%0b lo=%0b lock=%0b (t=%0t)",
                        g.code, g.dec, g.sat_hi, g.sat_lo, g.lock,
                        e.code, e.dec, e.sat_hi, e.sat_lo, e.lock, $time);
            end
         end
      end
   end

   task automatic step(input logic e, input logic p, input logic ld, input logic [7:0] lv);
      bus.en = e; bus.pd_q = p; bus.load = ld; bus.load_val = lv;
      @(posedge clk);
      #1;
   endtask

   // Expectation is pushed just before the deciding edge, so an early decision hits an empty queue.
   task automatic window(input logic [7:0] bits, input logic [7:0] c, input dec_t d,
                         input logic sh, input logic sl, input logic lk);
      for (int i = 0; i < 7; i++) step(1'b1, bits[i], 1'b0, 8'd0);
      sb_q.push_back('{code: c, dec: d, sat_hi: sh, sat_lo: sl, lock: lk});
      step(1'b1, bits[7], 1'b0, 8'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.en = 1'b0; bus.pd_q = 1'b0; bus.load = 1'b0; bus.load_val = 8'd0;
      #12;
      check("rst_code", bus.delay_code, 128);
      check("rst_dec", bus.dec, DEC_HOLD);
      check("rst_upd", bus.code_update, 0);
      check("rst_sat", {bus.sat_hi, bus.sat_lo}, 0);
      check("rst_lock", bus.lock, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Ramp
      window(8'hFF, 8'd129, DEC_UP, 1'b0, 1'b0, 1'b0);
      window(8'hFF, 8'd130, DEC_UP, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-window
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_code", bus.delay_code, 128);
      check("async_rst_dec", bus.dec, DEC_HOLD);
      check("async_rst_upd", bus.code_update, 0);
      check("async_rst_lock", bus.lock, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Alternating windows -> lock, then same-direction run -> unlock
      window(8'hFF, 8'd129, DEC_UP, 1'b0, 1'b0, 1'b0);
      window(8'h00, 8'd128, DEC_DN, 1'b0, 1'b0, 1'b0);
      window(8'hFF, 8'd129, DEC_UP, 1'b0, 1'b0, 1'b0);
      window(8'h00, 8'd128, DEC_DN, 1'b0, 1'b0, 1'b0);
      window(8'hFF, 8'd129, DEC_UP, 1'b0, 1'b0, 1'b1);
      window(8'hFF, 8'd130, DEC_UP, 1'b0, 1'b0, 1'b1);
      window(8'hFF, 8'd131, DEC_UP, 1'b0, 1'b0, 1'b1);
      window(8'hFF, 8'd132, DEC_UP, 1'b0, 1'b0, 1'b1);
      window(8'hFF, 8'd133, DEC_UP, 1'b0, 1'b0, 1'b0);

      // Tie -> HOLD
      step(1'b1, 1'b1, 1'b1, 8'd128);
      check("load_128", bus.delay_code, 128);
      window(8'h0F, 8'd128, DEC_HOLD, 1'b0, 1'b0, 1'b0);

      // Saturation high and low
      step(1'b1, 1'b0, 1'b1, 8'd255);
      check("load_255", bus.delay_code, 255);
      window(8'hFF, 8'd255, DEC_UP, 1'b1, 1'b0, 1'b0);
      window(8'h00, 8'd254, DEC_DN, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 8'd0);
      check("load_0", bus.delay_code, 0);
      window(8'h00, 8'd0, DEC_DN, 1'b0, 1'b1, 1'b0);
      window(8'hFF, 8'd1, DEC_UP, 1'b0, 1'b0, 1'b0);

      // Abort: partial window discarded while en=0
      step(1'b1, 1'b1, 1'b1, 8'd128);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
      check("abort_hold_code", bus.delay_code, 128);
      window(8'h00, 8'd127, DEC_DN, 1'b0, 1'b0, 1'b0);

      // Reach lock again, then load mid-window clears it and restarts the window
      window(8'hFF, 8'd128, DEC_UP, 1'b0, 1'b0, 1'b0);
      window(8'h00, 8'd127, DEC_DN, 1'b0, 1'b0, 1'b0);
      window(8'hFF, 8'd128, DEC_UP, 1'b0, 1'b0, 1'b0);
      window(8'h00, 8'd127, DEC_DN, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b1, 8'd50);
      check("load_mid_code", bus.delay_code, 50);
      check("load_mid_lock", bus.lock, 0);
      window(8'b1111_1000, 8'd51, DEC_UP, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
